// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizing constants and register-index type shared by the register file slice.
package regfile_pkg;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_NREG    = 32;
  localparam int DEF_SP_IDX  = 2;
  localparam int DEF_SP_INIT = 65536;
  localparam int DEF_AUX_IDX = 10;
  typedef logic [$clog2(DEF_NREG)-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, write, issue and scoreboard signals between a core and the register file.
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG
);
  localparam int AW = $clog2(NREG);
  logic [AW-1:0]   rs1, rs2, wb_rd, issue_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, wb_data, aux_data;
  logic            wb_we, aux_we, issue_valid, issue_ready, hazard, flush;
  logic [AW:0]     busy_cnt;
  modport master (
    output rs1, rs2, wb_we, wb_rd, wb_data, aux_we, aux_data, issue_valid, issue_rd, flush,
    input  rs1_data, rs2_data, issue_ready, hazard, busy_cnt
  );
  modport slave (
    input  rs1, rs2, wb_we, wb_rd, wb_data, aux_we, aux_data, issue_valid, issue_rd, flush,
    output rs1_data, rs2_data, issue_ready, hazard, busy_cnt
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// sb_scoreboard: per-register busy bits with issue set, writeback clear, flush and population count.
module sb_scoreboard import regfile_pkg::*; #(
  parameter int NREG    = DEF_NREG,
  parameter int AUX_IDX = DEF_AUX_IDX,
  localparam int AW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic          aux_we_i,
  input  logic          issue_valid_i,
  input  logic [AW-1:0] issue_rd_i,
  input  logic          flush_i,
  output logic          hazard_o,
  output logic          issue_ready_o,
  output logic [AW:0]   busy_cnt_o
);
  logic [NREG-1:0] busy_q, busy_d, clr, set;
  for (genvar i = 0; i < NREG; i++) begin : g_bit
    assign clr[i] = (wb_we_i && wb_rd_i == AW'(i)) || (aux_we_i && i == AUX_IDX);
    assign set[i] = issue_valid_i && issue_ready_o && i != 0 && issue_rd_i == AW'(i);
  end
  // a producer writing back this cycle no longer blocks its consumers
  assign hazard_o = (rs1_i != '0 && busy_q[rs1_i] && !clr[rs1_i]) ||
                    (rs2_i != '0 && busy_q[rs2_i] && !clr[rs2_i]);
  assign issue_ready_o = !hazard_o && !flush_i;
  assign busy_d = flush_i ? '0 : (busy_q & ~clr) | set;
  always_ff @(posedge clk) busy_q <= !rst ? '0 : busy_d;
  always_comb begin
    busy_cnt_o = '0;
    for (int k = 0; k < NREG; k++) busy_cnt_o = busy_cnt_o + (AW+1)'(busy_q[k]);
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-write-port register file with write-through reads and an issue scoreboard.
module regfile_sb import regfile_pkg::*; #(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREG    = DEF_NREG,
  parameter int SP_IDX  = DEF_SP_IDX,
  parameter int SP_INIT = DEF_SP_INIT,
  parameter int AUX_IDX = DEF_AUX_IDX
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_we && bus.wb_rd != '0) regs_d[bus.wb_rd] = bus.wb_data;
    if (bus.aux_we && AUX_IDX != 0) regs_d[AUX_IDX] = bus.aux_data;
  end
  always_ff @(posedge clk)
    for (int k = 0; k < NREG; k++)
      regs_q[k] <= !rst ? (k == SP_IDX ? XLEN'(SP_INIT) : '0) : regs_d[k];
  // aux wins over wb when both target the same register
  assign bus.rs1_data = bus.rs1 == '0 ? '0 :
                        (bus.aux_we && bus.rs1 == AW'(AUX_IDX)) ? bus.aux_data :
                        (bus.wb_we && bus.rs1 == bus.wb_rd) ? bus.wb_data : regs_q[bus.rs1];
  assign bus.rs2_data = bus.rs2 == '0 ? '0 :
                        (bus.aux_we && bus.rs2 == AW'(AUX_IDX)) ? bus.aux_data :
                        (bus.wb_we && bus.rs2 == bus.wb_rd) ? bus.wb_data : regs_q[bus.rs2];
  sb_scoreboard #(.NREG(NREG), .AUX_IDX(AUX_IDX)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .rs1_i         (bus.rs1),
    .rs2_i         (bus.rs2),
    .wb_we_i       (bus.wb_we),
    .wb_rd_i       (bus.wb_rd),
    .aux_we_i      (bus.aux_we),
    .issue_valid_i (bus.issue_valid),
    .issue_rd_i    (bus.issue_rd),
    .flush_i       (bus.flush),
    .hazard_o      (bus.hazard),
    .issue_ready_o (bus.issue_ready),
    .busy_cnt_o    (bus.busy_cnt)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven vectors with an expected-result queue for regfile_sb.
module tb_regfile_sb;
  import regfile_pkg::*;
  typedef struct {
    reg_idx_t rs1, rs2;
    logic wb_we; reg_idx_t wb_rd; logic [31:0] wb_data;
    logic aux_we; logic [31:0] aux_data;
    logic iv; reg_idx_t ird; logic flush;
    logic [31:0] e1, e2; logic ehz, erdy; logic [5:0] ecnt;
  } vec_t;
  typedef struct {logic [31:0] e1, e2; logic ehz, erdy; logic [5:0] ecnt; int id;} exp_t;
  logic clk = 0, rst = 0;
  int total = 0, bad = 0;
  vec_t vt [24];
  exp_t q [$];
  regfile_sb_if #(.XLEN(32), .NREG(32)) bus ();
  regfile_sb dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic vec_t mk(reg_idx_t rs1, reg_idx_t rs2, logic wb_we, reg_idx_t wb_rd,
      logic [31:0] wb_data, logic aux_we, logic [31:0] aux_data, logic iv, reg_idx_t ird,
      logic flush, logic [31:0] e1, logic [31:0] e2, logic ehz, logic erdy, logic [5:0] ecnt);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.wb_we = wb_we; v.wb_rd = wb_rd; v.wb_data = wb_data;
    v.aux_we = aux_we; v.aux_data = aux_data; v.iv = iv; v.ird = ird; v.flush = flush;
    v.e1 = e1; v.e2 = e2; v.ehz = ehz; v.erdy = erdy; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec%0d actual=%0h expected=%0h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.rs1 = v.rs1; bus.rs2 = v.rs2;
    bus.wb_we = v.wb_we; bus.wb_rd = v.wb_rd; bus.wb_data = v.wb_data;
    bus.aux_we = v.aux_we; bus.aux_data = v.aux_data;
    bus.issue_valid = v.iv; bus.issue_rd = v.ird; bus.flush = v.flush;
  endtask

  task automatic step(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    drive(v);
    q.push_back('{v.e1, v.e2, v.ehz, v.erdy, v.ecnt, id});
    #2;
    e = q.pop_front();
    chk("rs1_data", e.id, bus.rs1_data, e.e1);
    chk("rs2_data", e.id, bus.rs2_data, e.e2);
    chk("hazard", e.id, 32'(bus.hazard), 32'(e.ehz));
    chk("issue_ready", e.id, 32'(bus.issue_ready), 32'(e.erdy));
    chk("busy_cnt", e.id, 32'(bus.busy_cnt), 32'(e.ecnt));
  endtask

  initial begin
    vt[0]  = mk(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 65536, 0, 0, 1, 0);
    vt[1]  = mk(7, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0);
    vt[2]  = mk(7, 2, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 65536, 0, 1, 0);
    vt[3]  = mk(0, 10, 1, 10, 1, 1, 2, 0, 0, 0, 0, 2, 0, 1, 0);
    vt[4]  = mk(10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0);
    vt[6]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[7]  = mk(5, 0, 1, 5, 32'h55, 0, 0, 0, 0, 0, 32'h55, 0, 0, 1, 1);
    vt[8]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 1, 0);
    vt[9]  = mk(3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1, 1);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1, 2);
    vt[12] = mk(7, 2, 0, 0, 0, 0, 0, 1, 8, 1, 32'hDEADBEEF, 65536, 0, 0, 3);
    vt[13] = mk(8, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0);
    vt[14] = mk(0, 0, 1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    vt[15] = mk(0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    vt[16] = mk(12, 0, 1, 12, 32'h12, 0, 0, 1, 12, 0, 32'h12, 0, 0, 1, 0);
    vt[17] = mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12, 0, 1, 0, 1);
    vt[18] = mk(12, 10, 1, 12, 32'h99, 1, 32'hA5, 0, 0, 0, 32'h99, 32'hA5, 0, 1, 1);
    vt[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 1, 0);
    vt[20] = mk(0, 10, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'hA5, 1, 0, 1);
    vt[21] = mk(0, 10, 0, 0, 0, 1, 32'h77, 0, 0, 0, 0, 32'h77, 0, 1, 1);
    vt[22] = mk(10, 2, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77, 65536, 0, 1, 0);
    vt[23] = mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 24; i++) step(vt[i], i);
    // reset must beat a simultaneous writeback, aux write and issue
    @(negedge clk);
    rst = 0;
    drive(mk(0, 0, 1, 7, 32'h1111, 1, 32'h2222, 1, 9, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(7, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 100);
    step(mk(9, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 65536, 0, 1, 0), 101);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
